// File: rtl/fp_multifunc_sched.sv
// Round-robin scheduler that shares one floating-point multifunction unit between
// NUM_REQ valid/ready requesters and returns id-tagged results on one response channel.
module fp_multifunc_sched #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned SIG_WIDTH   = 23,
    parameter int unsigned EXP_WIDTH   = 8,
    parameter int unsigned FUNC_SELECT = 127,
    parameter int unsigned LATENCY     = 1,
    localparam int unsigned W          = SIG_WIDTH + EXP_WIDTH + 1,
    localparam int unsigned IDW        = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_REQ-1:0]     req_valid,
    output logic [NUM_REQ-1:0]     req_ready,
    input  logic [NUM_REQ*W-1:0]   req_a,
    input  logic [NUM_REQ*16-1:0]  req_func,
    input  logic [NUM_REQ*3-1:0]   req_rnd,
    output logic                   rsp_valid,
    input  logic                   rsp_ready,
    output logic [IDW-1:0]         rsp_id,
    output logic [W-1:0]           rsp_z,
    output logic [7:0]             rsp_status,
    output logic [W-1:0]           fu_a,
    output logic [15:0]            fu_func,
    output logic [2:0]             fu_rnd,
    input  logic [W-1:0]           fu_z,
    input  logic [7:0]             fu_status,
    output logic                   busy
);

    localparam int unsigned    CW       = (LATENCY > 1) ? $clog2(LATENCY) : 1;
    localparam logic [CW-1:0]  CNT_LAST = CW'(LATENCY - 1);
    localparam logic [15:0]    FS_MASK  = 16'(FUNC_SELECT);
    localparam logic [7:0]     ST_INVALID = 8'h04;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t           state, state_nxt;
    logic [IDW-1:0]   ptr, ptr_nxt;
    logic [IDW-1:0]   cur_id, cur_id_nxt;
    logic [CW-1:0]    cnt, cnt_nxt;
    logic             rsp_valid_nxt, busy_nxt;
    logic [IDW-1:0]   rsp_id_nxt;
    logic [W-1:0]     rsp_z_nxt, fu_a_nxt;
    logic [7:0]       rsp_status_nxt;
    logic [15:0]      fu_func_nxt;
    logic [2:0]       fu_rnd_nxt;
    logic [NUM_REQ-1:0] grant_c;

    // Per-requester views of the flattened request buses
    logic [W-1:0]  a_arr    [NUM_REQ];
    logic [15:0]   func_arr [NUM_REQ];
    logic [2:0]    rnd_arr  [NUM_REQ];

    always_comb begin
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            a_arr[i]    = req_a[i*W +: W];
            func_arr[i] = req_func[i*16 +: 16];
            rnd_arr[i]  = req_rnd[i*3 +: 3];
        end
    end

    // Round-robin pick: first valid requester at or after the pointer, with wrap
    logic            gnt_any;
    logic [IDW-1:0]  gnt_id;
    int unsigned     scan;

    always_comb begin
        gnt_any = 1'b0;
        gnt_id  = '0;
        scan    = 0;
        for (int unsigned k = 0; k < NUM_REQ; k++) begin
            scan = 32'(ptr) + k;
            if (scan >= NUM_REQ) begin
                scan = scan - NUM_REQ;
            end
            if (!gnt_any && req_valid[scan[IDW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_id  = scan[IDW-1:0];
            end
        end
    end

    // A request may reach the unit only with a single enabled function bit
    logic [15:0] g_func;
    logic        g_legal;

    assign g_func  = func_arr[gnt_id];
    assign g_legal = (g_func != 16'h0)
                  && ((g_func & (g_func - 16'h1)) == 16'h0)
                  && ((g_func & FS_MASK) != 16'h0);

    always_comb begin
        state_nxt      = state;
        ptr_nxt        = ptr;
        cur_id_nxt     = cur_id;
        cnt_nxt        = cnt;
        rsp_valid_nxt  = rsp_valid;
        rsp_id_nxt     = rsp_id;
        rsp_z_nxt      = rsp_z;
        rsp_status_nxt = rsp_status;
        fu_a_nxt       = fu_a;
        fu_func_nxt    = fu_func;
        fu_rnd_nxt     = fu_rnd;
        grant_c        = '0;

        case (state)
            S_IDLE: begin
                if (gnt_any) begin
                    grant_c[gnt_id] = 1'b1;
                    ptr_nxt = (gnt_id == IDW'(NUM_REQ - 1)) ? '0 : gnt_id + IDW'(1);
                    if (g_legal) begin
                        fu_a_nxt    = a_arr[gnt_id];
                        fu_func_nxt = g_func;
                        fu_rnd_nxt  = rnd_arr[gnt_id];
                        cur_id_nxt  = gnt_id;
                        cnt_nxt     = '0;
                        state_nxt   = S_EXEC;
                    end else begin
                        rsp_z_nxt      = '0;
                        rsp_status_nxt = ST_INVALID;
                        rsp_id_nxt     = gnt_id;
                        rsp_valid_nxt  = 1'b1;
                        state_nxt      = S_RESP;
                    end
                end
            end
            S_EXEC: begin
                cnt_nxt = cnt + CW'(1);
                if (cnt == CNT_LAST) begin
                    rsp_z_nxt      = fu_z;
                    rsp_status_nxt = fu_status;
                    rsp_id_nxt     = cur_id;
                    rsp_valid_nxt  = 1'b1;
                    state_nxt      = S_RESP;
                end
            end
            S_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_nxt = 1'b0;
                    state_nxt     = S_IDLE;
                end
            end
            default: begin
                state_nxt = S_IDLE;
            end
        endcase

        busy_nxt = (state_nxt != S_IDLE);
    end

    assign req_ready = rst ? '0 : grant_c;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= S_IDLE;
            ptr        <= '0;
            cur_id     <= '0;
            cnt        <= '0;
            rsp_valid  <= 1'b0;
            rsp_id     <= '0;
            rsp_z      <= '0;
            rsp_status <= '0;
            fu_a       <= '0;
            fu_func    <= '0;
            fu_rnd     <= '0;
            busy       <= 1'b0;
        end else begin
            state      <= state_nxt;
            ptr        <= ptr_nxt;
            cur_id     <= cur_id_nxt;
            cnt        <= cnt_nxt;
            rsp_valid  <= rsp_valid_nxt;
            rsp_id     <= rsp_id_nxt;
            rsp_z      <= rsp_z_nxt;
            rsp_status <= rsp_status_nxt;
            fu_a       <= fu_a_nxt;
            fu_func    <= fu_func_nxt;
            fu_rnd     <= fu_rnd_nxt;
            busy       <= busy_nxt;
        end
    end

endmodule

// File: doc/fp_multifunc_sched.md
Name: fp_multifunc_sched

Overview:
- Round-robin scheduler that shares one DW_lp_fp_multifunc datapath between NUM_REQ requesters.
- Each requester issues over a valid/ready channel; the block arbitrates and registers operands into the shared unit.
- It waits a fixed unit latency, then returns the result tagged with the requester id on one valid/ready response channel.
- One operation is in flight at a time.
- Illegal func codes are rejected locally and never reach the unit.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- SIG_WIDTH, 23, significand width passed to the shared unit.
- EXP_WIDTH, 8, exponent width passed to the shared unit.
- FUNC_SELECT, 127, 16-bit mask of functions enabled in the shared unit.
- LATENCY, 1, cycles (>=1) from fu_* inputs stable to fu_z/fu_status valid.
- Derived: W = SIG_WIDTH+EXP_WIDTH+1; IDW = max(1, clog2(NUM_REQ)).

Ports:
- clk in 1: clock, all logic on rising edge.
- rst in 1: synchronous active-high reset.
- req_valid in NUM_REQ: per-requester request valid.
- req_ready out NUM_REQ: per-requester accept, at most one bit high.
- req_a in NUM_REQ*W: operands, requester i at [i*W +: W].
- req_func in NUM_REQ*16: function codes, one-hot, requester i at [i*16 +: 16].
- req_rnd in NUM_REQ*3: rounding modes.
- rsp_valid out 1: response valid.
- rsp_ready in 1: response accept.
- rsp_id out IDW: index of the requester being answered.
- rsp_z out W: result.
- rsp_status out 8: DW status byte.
- fu_a out W: to shared unit a.
- fu_func out 16: to shared unit func.
- fu_rnd out 3: to shared unit rnd.
- fu_z in W: from shared unit z.
- fu_status in 8: from shared unit status.
- busy out 1: high when state != IDLE.

Behaviour:
- Reset (rst=1 at a clk edge):
  - state=IDLE, rr pointer=0, exec counter=0.
  - rsp_valid=0; rsp_id, rsp_z, rsp_status = 0.
  - fu_a, fu_func, fu_rnd = 0.
  - req_ready = 0 while rst is high.
- Reset mid-operation aborts the in-flight op; no response is ever produced for it.
- States:
  - IDLE: grant if any req_valid.
  - EXEC: wait LATENCY cycles.
  - RESP: hold response until rsp_ready.
- Arbitration (IDLE only):
  - Winner g = first i with req_valid[i]=1, scanning from pointer upward with wrap.
  - req_ready[g]=1 combinationally in the same cycle; all other req_ready bits are 0.
  - Outside IDLE, req_ready=0.
  - On grant, pointer <= (g+1) mod NUM_REQ.
  - Pointer is unchanged when nothing is granted.
  - Grant depends only on req_valid and pointer, never on req_ready, so there is no combinational loop.
- Legality check on the granted request:
  - Legal iff req_func is exactly one-hot and (req_func & FUNC_SELECT) != 0.
  - Legal: fu_a/fu_func/fu_rnd <= granted fields; id register <= g; counter <= 0; state <= EXEC.
  - Illegal: fu_* keep their previous values; rsp_z <= 0; rsp_status <= 8'h04 (invalid); rsp_id <= g; state <= RESP.
- EXEC:
  - fu_* held stable; counter increments each cycle.
  - In the cycle where counter == LATENCY-1: rsp_z <= fu_z, rsp_status <= fu_status, rsp_id <= id register, state <= RESP.
- Timing:
  - Accept edge to rsp_valid high is LATENCY+1 cycles for a legal op.
  - Accept edge to rsp_valid high is 1 cycle for an illegal op.
- RESP:
  - rsp_valid=1; rsp_id/rsp_z/rsp_status are stable until the handshake.
  - On rsp_valid & rsp_ready: rsp_valid <= 0, state <= IDLE.
  - No new grant in the handshake cycle; the earliest next accept is the following cycle.
- Throughput: one legal op per LATENCY+2 cycles when rsp_ready is tied high.
- Backpressure: rsp_ready low holds RESP indefinitely; all req_ready stay 0.
- Request-side rules:
  - A requester may deassert req_valid before being granted; the block does not check this.
  - Operands are sampled only at the grant edge.
- fu_* registered outputs change only at a legal grant or at reset.

Test Plan:
- Reset then a single legal request: req0 valid, func=16'h0001, a=32'h3F800000, LATENCY=1, unit model returns z=32'h3F800000, status=0 -> req_ready[0] high in accept cycle; rsp_valid high 2 cycles later with rsp_id=0, rsp_z=32'h3F800000, rsp_status=0; busy drops the cycle after the handshake.
- Fairness: all 4 req_valid held high, rsp_ready=1 -> grants in order 0,1,2,3,0,...; each grant spaced LATENCY+2 cycles.
- Illegal func:
  - req2 with func=16'h0003 -> rsp_valid 1 cycle after accept; rsp_id=2, rsp_z=0, rsp_status=8'h04; fu_* unchanged.
  - Same for func=16'h0100 with FUNC_SELECT=127.
- Backpressure: rsp_ready=0 for 10 cycles during RESP with req1 valid -> rsp_* stable, req_ready all 0; on release, req1 is granted the cycle after the handshake.
- Reset mid-EXEC with LATENCY=4: rst pulsed at EXEC cycle 2 -> no rsp_valid ever for that op; fu_*, rsp_* = 0; pointer=0, so req0 wins the next contest against req3.
- Pointer wrap: NUM_REQ=4, after a grant to req3 with req0 and req2 both valid -> req0 granted next.
